// File: rtl/tlp_axi_pkg.sv
// Shared types and constants for the TLP-to-AXI master bridge.
package tlp_axi_pkg;

  localparam int unsigned FMT_W      = 7;
  localparam int unsigned LEN_W      = 10;
  localparam int unsigned DW_W       = 32;
  localparam int unsigned BE_W       = 4;
  localparam int unsigned TID_W      = 24;
  localparam int unsigned BC_W       = 12;
  localparam int unsigned LA_W       = 7;
  localparam int unsigned ATTR_W     = 2;
  localparam int unsigned TLP_ADDR_W = 64;

  localparam logic [FMT_W-1:0] FMT_MRD32 = 7'h00;
  localparam logic [FMT_W-1:0] FMT_MRD64 = 7'h20;
  localparam logic [FMT_W-1:0] FMT_MWR32 = 7'h40;
  localparam logic [FMT_W-1:0] FMT_MWR64 = 7'h60;
  localparam logic [FMT_W-1:0] FMT_CPL   = 7'h0A;
  localparam logic [FMT_W-1:0] FMT_CPLD  = 7'h4A;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic [2:0] CPL_STATUS_SC = 3'b000;
  localparam logic [2:0] CPL_STATUS_UR = 3'b001;
  localparam logic [2:0] CPL_STATUS_CA = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_CPL_REQ,
    ST_CPL_DATA
  } state_e;

  // Request fields kept for the lifetime of one transaction
  typedef struct packed {
    logic [TLP_ADDR_W-1:0] address;
    logic [ATTR_W-1:0]     attr;
    logic [TID_W-1:0]      tid;
    logic [DW_W-1:0]       data;
    logic [BE_W-1:0]       byte_en;
    logic [BC_W-1:0]       byte_count;
  } req_hdr_t;

  typedef struct packed {
    logic [FMT_W-1:0]      fmt_type;
    logic [LEN_W-1:0]      length_in_dw;
    logic [DW_W-1:0]       data;
    logic [TLP_ADDR_W-1:0] address;
    logic [7:0]            ldwbe_fdwbe;
    logic [ATTR_W-1:0]     attr;
    logic [TID_W-1:0]      transaction_id;
    logic [BC_W-1:0]       byte_count;
    logic [LA_W-1:0]       lower_address;
  } cpl_fields_t;

  // Byte offset of the lowest enabled byte; zero when no byte is enabled
  function automatic logic [1:0] first_be_offset(input logic [BE_W-1:0] be);
    if (be[0])      return 2'd0;
    else if (be[1]) return 2'd1;
    else if (be[2]) return 2'd2;
    else if (be[3]) return 2'd3;
    else            return 2'd0;
  endfunction

endpackage

// File: rtl/tlp_cpl_builder.sv
// Formats completion TLP fields from the latched request and read data.
module tlp_cpl_builder
  import tlp_axi_pkg::*;
(
  input  logic [TLP_ADDR_W-1:0] address,
  input  logic [BE_W-1:0]       byte_en,
  input  logic [ATTR_W-1:0]     attr,
  input  logic [TID_W-1:0]      tid,
  input  logic [BC_W-1:0]       byte_count,
  input  logic [DW_W-1:0]       rdata,
  input  logic                  no_data,
  output cpl_fields_t           cpl_c
);

  always_comb begin
    cpl_c                = '0;
    cpl_c.fmt_type       = no_data ? FMT_CPL : FMT_CPLD;
    cpl_c.length_in_dw   = no_data ? LEN_W'(0) : LEN_W'(1);
    cpl_c.data           = no_data ? DW_W'(0) : rdata;
    cpl_c.address        = address;
    cpl_c.ldwbe_fdwbe    = {4'h0, byte_en};
    cpl_c.attr           = attr;
    cpl_c.transaction_id = tid;
    cpl_c.byte_count     = byte_count;
    cpl_c.lower_address  = {address[6:2], first_be_offset(byte_en)};
  end

endmodule

// File: rtl/tlp_axi_master_bridge.sv
// Single-DW PCIe memory request to AXI4 master bridge with CplD return path.
// Optional TLP2AXI_UR_CPL_EN: UR/CA completions for bad reads and error responses.
module tlp_axi_master_bridge
  import tlp_axi_pkg::*;
#(
  parameter int unsigned AXI_ID_W   = 4,
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_DATA_W = 32
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset_n,
  input  logic                  tlp_in_valid,
  output logic                  tlp_in_accept_data,
  input  logic [6:0]            tlp_in_fmt_type,
  input  logic [63:0]           tlp_in_address,
  input  logic [9:0]            tlp_in_length_in_dw,
  input  logic [1:0]            tlp_in_attr,
  input  logic [23:0]           tlp_in_transaction_id,
  input  logic [31:0]           tlp_in_data,
  input  logic [3:0]            tlp_in_byte_en,
  input  logic [11:0]           tlp_in_byte_count,
  output logic                  tlp_out_req_to_send,
  input  logic                  tlp_out_grant,
  output logic                  tlp_out_src_rdy_n,
  input  logic                  tlp_out_dst_rdy_n,
  output logic [6:0]            tlp_out_fmt_type,
  output logic [9:0]            tlp_out_length_in_dw,
  output logic [31:0]           tlp_out_data,
  output logic [63:0]           tlp_out_address,
  output logic [7:0]            tlp_out_ldwbe_fdwbe,
  output logic [1:0]            tlp_out_attr,
  output logic [23:0]           tlp_out_transaction_id,
  output logic [11:0]           tlp_out_byte_count,
  output logic [6:0]            tlp_out_lower_address,
`ifdef TLP2AXI_UR_CPL_EN
  output logic [2:0]            tlp_out_cpl_status,
`endif
  input  logic                  M_AXI_AWREADY,
  output logic                  M_AXI_AWVALID,
  output logic [AXI_ID_W-1:0]   M_AXI_AWID,
  output logic [AXI_ADDR_W-1:0] M_AXI_AWADDR,
  output logic [7:0]            M_AXI_AWLEN,
  output logic [2:0]            M_AXI_AWSIZE,
  output logic [1:0]            M_AXI_AWBURST,
  output logic [2:0]            M_AXI_AWPROT,
  input  logic                  M_AXI_WREADY,
  output logic                  M_AXI_WVALID,
  output logic [AXI_DATA_W-1:0] M_AXI_WDATA,
  output logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_WLAST,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  input  logic [AXI_ID_W-1:0]   M_AXI_BID,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_ARREADY,
  output logic                  M_AXI_ARVALID,
  output logic [AXI_ID_W-1:0]   M_AXI_ARID,
  output logic [AXI_ADDR_W-1:0] M_AXI_ARADDR,
  output logic [7:0]            M_AXI_ARLEN,
  output logic [2:0]            M_AXI_ARSIZE,
  output logic [1:0]            M_AXI_ARBURST,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,
  input  logic [AXI_ID_W-1:0]   M_AXI_RID,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RLAST,
  input  logic [AXI_DATA_W-1:0] M_AXI_RDATA
);

  state_e          state_q, state_d;
  req_hdr_t        hdr_q, hdr_d;
  logic [DW_W-1:0] rdata_q, rdata_d;
  cpl_fields_t     cpl_q, cpl_d, cpl_c;
  logic            accept_q, accept_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic            req_q, req_d;
  logic            src_rdy_n_q, src_rdy_n_d;
  logic            no_data_c;

  logic is_mwr_c, is_mrd_c, len_one_c;
  assign is_mwr_c  = (tlp_in_fmt_type == FMT_MWR32) || (tlp_in_fmt_type == FMT_MWR64);
  assign is_mrd_c  = (tlp_in_fmt_type == FMT_MRD32) || (tlp_in_fmt_type == FMT_MRD64);
  assign len_one_c = (tlp_in_length_in_dw == LEN_W'(1));

`ifdef TLP2AXI_UR_CPL_EN
  logic       no_data_q, no_data_d;
  logic [2:0] status_q, status_d, status_out_q, status_out_d;
  assign no_data_c = no_data_q;
`else
  assign no_data_c = 1'b0;
`endif

  tlp_cpl_builder u_cpl_builder (
    .address    (hdr_q.address),
    .byte_en    (hdr_q.byte_en),
    .attr       (hdr_q.attr),
    .tid        (hdr_q.tid),
    .byte_count (hdr_q.byte_count),
    .rdata      (rdata_q),
    .no_data    (no_data_c),
    .cpl_c      (cpl_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    rdata_d     = rdata_q;
    cpl_d       = cpl_q;
    accept_d    = 1'b0;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    req_d       = req_q;
    src_rdy_n_d = src_rdy_n_q;
`ifdef TLP2AXI_UR_CPL_EN
    no_data_d    = no_data_q;
    status_d     = status_q;
    status_out_d = status_out_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // accept_q masks the request still held high in the cycle after acceptance
        if (tlp_in_valid && !accept_q) begin
          accept_d         = 1'b1;
          hdr_d.address    = tlp_in_address;
          hdr_d.attr       = tlp_in_attr;
          hdr_d.tid        = tlp_in_transaction_id;
          hdr_d.data       = tlp_in_data;
          hdr_d.byte_en    = tlp_in_byte_en;
          hdr_d.byte_count = tlp_in_byte_count;
`ifdef TLP2AXI_UR_CPL_EN
          no_data_d = 1'b0;
          status_d  = CPL_STATUS_SC;
`endif
          if (is_mwr_c && len_one_c) begin
            state_d = ST_WR_REQ;
          end else if (is_mrd_c && len_one_c) begin
            state_d = ST_RD_REQ;
          end
`ifdef TLP2AXI_UR_CPL_EN
          else if (!tlp_in_fmt_type[6]) begin
            no_data_d = 1'b1;
            status_d  = CPL_STATUS_UR;
            req_d     = 1'b1;
            state_d   = ST_CPL_REQ;
          end
`endif
        end
      end
      ST_WR_REQ: begin
        if (accept_q) begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end else begin
          if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
          if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
          if (!awvalid_d && !wvalid_d) begin
            bready_d = 1'b1;
            state_d  = ST_WR_RESP;
          end
        end
      end
      ST_WR_RESP: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        if (accept_q) begin
          arvalid_d = 1'b1;
        end else if (arvalid_q && M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (M_AXI_RVALID) begin
          rdata_d  = DW_W'(M_AXI_RDATA);
          rready_d = 1'b0;
          req_d    = 1'b1;
          state_d  = ST_CPL_REQ;
`ifdef TLP2AXI_UR_CPL_EN
          if (M_AXI_RRESP != AXI_RESP_OKAY) begin
            no_data_d = 1'b1;
            status_d  = CPL_STATUS_CA;
          end
`endif
        end
      end
      ST_CPL_REQ: begin
        if (tlp_out_grant) begin
          cpl_d       = cpl_c;
          src_rdy_n_d = 1'b0;
          state_d     = ST_CPL_DATA;
`ifdef TLP2AXI_UR_CPL_EN
          status_out_d = status_q;
`endif
        end
      end
      ST_CPL_DATA: begin
        if (!tlp_out_dst_rdy_n) begin
          src_rdy_n_d = 1'b1;
          req_d       = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q     <= ST_IDLE;
      hdr_q       <= '0;
      rdata_q     <= '0;
      cpl_q       <= '0;
      accept_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      req_q       <= 1'b0;
      src_rdy_n_q <= 1'b1;
`ifdef TLP2AXI_UR_CPL_EN
      no_data_q    <= 1'b0;
      status_q     <= CPL_STATUS_SC;
      status_out_q <= CPL_STATUS_SC;
`endif
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      rdata_q     <= rdata_d;
      cpl_q       <= cpl_d;
      accept_q    <= accept_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      req_q       <= req_d;
      src_rdy_n_q <= src_rdy_n_d;
`ifdef TLP2AXI_UR_CPL_EN
      no_data_q    <= no_data_d;
      status_q     <= status_d;
      status_out_q <= status_out_d;
`endif
    end
  end

  logic [AXI_ADDR_W-1:0] axi_addr;
  assign axi_addr = {hdr_q.address[AXI_ADDR_W-1:2], 2'b00};

  assign tlp_in_accept_data     = accept_q;
  assign tlp_out_req_to_send    = req_q;
  assign tlp_out_src_rdy_n      = src_rdy_n_q;
  assign tlp_out_fmt_type       = cpl_q.fmt_type;
  assign tlp_out_length_in_dw   = cpl_q.length_in_dw;
  assign tlp_out_data           = cpl_q.data;
  assign tlp_out_address        = cpl_q.address;
  assign tlp_out_ldwbe_fdwbe    = cpl_q.ldwbe_fdwbe;
  assign tlp_out_attr           = cpl_q.attr;
  assign tlp_out_transaction_id = cpl_q.transaction_id;
  assign tlp_out_byte_count     = cpl_q.byte_count;
  assign tlp_out_lower_address  = cpl_q.lower_address;
`ifdef TLP2AXI_UR_CPL_EN
  assign tlp_out_cpl_status     = status_out_q;
`endif

  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = axi_addr;
  assign M_AXI_AWLEN   = 8'd0;
  assign M_AXI_AWSIZE  = AXI_SIZE_4B;
  assign M_AXI_AWBURST = AXI_BURST_INCR;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_WDATA   = AXI_DATA_W'(hdr_q.data);
  assign M_AXI_WSTRB   = hdr_q.byte_en;
  assign M_AXI_WLAST   = 1'b1;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = axi_addr;
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = AXI_SIZE_4B;
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_RREADY  = rready_q;

  // Response IDs, BRESP and RLAST carry no information for single-beat, single-ID traffic
  logic unused_ok;
`ifdef TLP2AXI_UR_CPL_EN
  assign unused_ok = ^{M_AXI_BID, M_AXI_BRESP, M_AXI_RID, M_AXI_RLAST};
`else
  assign unused_ok = ^{M_AXI_BID, M_AXI_BRESP, M_AXI_RID, M_AXI_RLAST, M_AXI_RRESP};
`endif

endmodule

// File: tb/tb_tlp_axi_master_bridge.sv
// Directed self-checking bench for tlp_axi_master_bridge (default build).
module tb_tlp_axi_master_bridge;

  logic        sys_clk = 1'b0;
  logic        sys_reset_n;
  logic        tlp_in_valid, tlp_in_accept_data;
  logic [6:0]  tlp_in_fmt_type;
  logic [63:0] tlp_in_address;
  logic [9:0]  tlp_in_length_in_dw;
  logic [1:0]  tlp_in_attr;
  logic [23:0] tlp_in_transaction_id;
  logic [31:0] tlp_in_data;
  logic [3:0]  tlp_in_byte_en;
  logic [11:0] tlp_in_byte_count;
  logic        tlp_out_req_to_send, tlp_out_grant, tlp_out_src_rdy_n, tlp_out_dst_rdy_n;
  logic [6:0]  tlp_out_fmt_type;
  logic [9:0]  tlp_out_length_in_dw;
  logic [31:0] tlp_out_data;
  logic [63:0] tlp_out_address;
  logic [7:0]  tlp_out_ldwbe_fdwbe;
  logic [1:0]  tlp_out_attr;
  logic [23:0] tlp_out_transaction_id;
  logic [11:0] tlp_out_byte_count;
  logic [6:0]  tlp_out_lower_address;
  logic        M_AXI_AWREADY, M_AXI_AWVALID;
  logic [3:0]  M_AXI_AWID;
  logic [31:0] M_AXI_AWADDR;
  logic [7:0]  M_AXI_AWLEN;
  logic [2:0]  M_AXI_AWSIZE;
  logic [1:0]  M_AXI_AWBURST;
  logic [2:0]  M_AXI_AWPROT;
  logic        M_AXI_WREADY, M_AXI_WVALID;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WLAST, M_AXI_BVALID, M_AXI_BREADY;
  logic [3:0]  M_AXI_BID;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_ARREADY, M_AXI_ARVALID;
  logic [3:0]  M_AXI_ARID;
  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_RVALID, M_AXI_RREADY;
  logic [3:0]  M_AXI_RID;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST;
  logic [31:0] M_AXI_RDATA;

  int checks = 0;
  int errors = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, cpl_cnt = 0;

  tlp_axi_master_bridge dut (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
    .tlp_in_valid(tlp_in_valid), .tlp_in_accept_data(tlp_in_accept_data),
    .tlp_in_fmt_type(tlp_in_fmt_type), .tlp_in_address(tlp_in_address),
    .tlp_in_length_in_dw(tlp_in_length_in_dw), .tlp_in_attr(tlp_in_attr),
    .tlp_in_transaction_id(tlp_in_transaction_id), .tlp_in_data(tlp_in_data),
    .tlp_in_byte_en(tlp_in_byte_en), .tlp_in_byte_count(tlp_in_byte_count),
    .tlp_out_req_to_send(tlp_out_req_to_send), .tlp_out_grant(tlp_out_grant),
    .tlp_out_src_rdy_n(tlp_out_src_rdy_n), .tlp_out_dst_rdy_n(tlp_out_dst_rdy_n),
    .tlp_out_fmt_type(tlp_out_fmt_type), .tlp_out_length_in_dw(tlp_out_length_in_dw),
    .tlp_out_data(tlp_out_data), .tlp_out_address(tlp_out_address),
    .tlp_out_ldwbe_fdwbe(tlp_out_ldwbe_fdwbe), .tlp_out_attr(tlp_out_attr),
    .tlp_out_transaction_id(tlp_out_transaction_id), .tlp_out_byte_count(tlp_out_byte_count),
    .tlp_out_lower_address(tlp_out_lower_address),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWID(M_AXI_AWID),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE),
    .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WDATA(M_AXI_WDATA),
    .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BID(M_AXI_BID),
    .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARID(M_AXI_ARID),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY), .M_AXI_RID(M_AXI_RID),
    .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RDATA(M_AXI_RDATA)
  );

  always #5 sys_clk = ~sys_clk;

  // Handshake counters used to prove single transfers and absence of traffic
  always @(posedge sys_clk) begin
    if (M_AXI_AWVALID && M_AXI_AWREADY) aw_cnt <= aw_cnt + 1;
    if (M_AXI_WVALID && M_AXI_WREADY)   w_cnt  <= w_cnt + 1;
    if (M_AXI_ARVALID && M_AXI_ARREADY) ar_cnt <= ar_cnt + 1;
    if (!tlp_out_src_rdy_n && !tlp_out_dst_rdy_n) cpl_cnt <= cpl_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_tlp(input logic [6:0] fmt, input logic [63:0] addr, input logic [9:0] len,
                          input logic [23:0] tid, input logic [31:0] data, input logic [3:0] be,
                          input logic [11:0] bc, input logic [1:0] attr);
    int n;
    tlp_in_fmt_type = fmt;  tlp_in_address = addr; tlp_in_length_in_dw = len;
    tlp_in_transaction_id = tid; tlp_in_data = data; tlp_in_byte_en = be;
    tlp_in_byte_count = bc; tlp_in_attr = attr;
    tlp_in_valid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!tlp_in_accept_data && n < 20);
    tlp_in_valid = 1'b0;
    chk("accept", tlp_in_accept_data, 1'b1);
  endtask

  task automatic wr_txn(input logic [6:0] fmt, input logic [63:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input logic [31:0] exp_awaddr, input int aw_dly);
    int aw0, w0, c0;
    aw0 = aw_cnt; w0 = w_cnt; c0 = cpl_cnt;
    M_AXI_AWREADY = (aw_dly == 0);
    M_AXI_WREADY  = 1'b1;
    send_tlp(fmt, addr, 10'd1, 24'h0, data, be, 12'd4, 2'd0);
    chk("awvalid_in_accept_cycle", M_AXI_AWVALID, 1'b0);
    tick();
    chk("accept_pulse_len", tlp_in_accept_data, 1'b0);
    chk("awvalid_rise", M_AXI_AWVALID, 1'b1);
    chk("wvalid_rise", M_AXI_WVALID, 1'b1);
    chk("awaddr", M_AXI_AWADDR, exp_awaddr);
    chk("wdata", M_AXI_WDATA, data);
    chk("wstrb", M_AXI_WSTRB, be);
    chk("wlast", M_AXI_WLAST, 1'b1);
    if (aw_dly > 0) begin
      tick();
      chk("wvalid_drop_first", M_AXI_WVALID, 1'b0);
      chk("awvalid_held", M_AXI_AWVALID, 1'b1);
      tlp_in_valid = 1'b1;
      for (int i = 0; i < aw_dly - 2; i++) begin
        tick();
        chk("awvalid_stall", M_AXI_AWVALID, 1'b1);
        chk("no_accept_busy", tlp_in_accept_data, 1'b0);
      end
      tlp_in_valid  = 1'b0;
      M_AXI_AWREADY = 1'b1;
    end
    tick();
    M_AXI_AWREADY = 1'b0;
    chk("awvalid_done", M_AXI_AWVALID, 1'b0);
    chk("wvalid_done", M_AXI_WVALID, 1'b0);
    chk("bready", M_AXI_BREADY, 1'b1);
    M_AXI_BVALID = 1'b1;
    tick();
    M_AXI_BVALID = 1'b0;
    chk("bready_drop", M_AXI_BREADY, 1'b0);
    chk("aw_count", 64'(aw_cnt), 64'(aw0 + 1));
    chk("w_count", 64'(w_cnt), 64'(w0 + 1));
    chk("no_cpl_for_write", 64'(cpl_cnt), 64'(c0));
    chk("no_rts_for_write", tlp_out_req_to_send, 1'b0);
  endtask

  task automatic rd_txn(input logic [63:0] addr, input logic [23:0] tid, input logic [3:0] be,
                        input logic [11:0] bc, input logic [1:0] attr, input logic [31:0] rdata,
                        input logic [31:0] exp_araddr, input logic [6:0] exp_la,
                        input int grant_dly, input int dst_dly);
    int n;
    M_AXI_ARREADY = 1'b1;
    send_tlp(7'h00, addr, 10'd1, tid, 32'h0, be, bc, attr);
    n = 0;
    while (!M_AXI_ARVALID && n < 20) begin tick(); n++; end
    chk("arvalid", M_AXI_ARVALID, 1'b1);
    chk("araddr", M_AXI_ARADDR, exp_araddr);
    tick();
    M_AXI_ARREADY = 1'b0;
    chk("arvalid_drop", M_AXI_ARVALID, 1'b0);
    chk("rready", M_AXI_RREADY, 1'b1);
    M_AXI_RVALID = 1'b1; M_AXI_RDATA = rdata; M_AXI_RRESP = 2'b00; M_AXI_RLAST = 1'b1;
    tick();
    M_AXI_RVALID = 1'b0;
    chk("rready_drop", M_AXI_RREADY, 1'b0);
    chk("req_to_send", tlp_out_req_to_send, 1'b1);
    for (int i = 0; i < grant_dly; i++) begin
      tick();
      chk("req_to_send_held", tlp_out_req_to_send, 1'b1);
      chk("src_rdy_n_wait_grant", tlp_out_src_rdy_n, 1'b1);
    end
    tlp_out_grant = 1'b1;
    tlp_out_dst_rdy_n = 1'b1;
    tick();
    tlp_out_grant = 1'b0;
    for (int i = 0; i <= dst_dly; i++) begin
      if (i == dst_dly) tlp_out_dst_rdy_n = 1'b0;
      chk("src_rdy_n_low", tlp_out_src_rdy_n, 1'b0);
      chk("req_to_send_cpl", tlp_out_req_to_send, 1'b1);
      chk("cpl_fmt", tlp_out_fmt_type, 7'h4A);
      chk("cpl_len", tlp_out_length_in_dw, 10'd1);
      chk("cpl_data", tlp_out_data, rdata);
      chk("cpl_tid", tlp_out_transaction_id, tid);
      chk("cpl_lower_addr", tlp_out_lower_address, exp_la);
      chk("cpl_ldwbe_fdwbe", tlp_out_ldwbe_fdwbe, {4'h0, be});
      chk("cpl_byte_count", tlp_out_byte_count, bc);
      chk("cpl_attr", tlp_out_attr, attr);
      chk("cpl_address", tlp_out_address, addr);
      tick();
    end
    tlp_out_dst_rdy_n = 1'b1;
    chk("src_rdy_n_release", tlp_out_src_rdy_n, 1'b1);
    chk("req_to_send_release", tlp_out_req_to_send, 1'b0);
  endtask

  initial begin
    int aw0, ar0, c0;
    sys_reset_n = 1'b0;
    tlp_in_valid = 1'b0; tlp_in_fmt_type = '0; tlp_in_address = '0; tlp_in_length_in_dw = '0;
    tlp_in_attr = '0; tlp_in_transaction_id = '0; tlp_in_data = '0; tlp_in_byte_en = '0;
    tlp_in_byte_count = '0; tlp_out_grant = 1'b0; tlp_out_dst_rdy_n = 1'b1;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BID = '0;
    M_AXI_BRESP = '0; M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RID = '0;
    M_AXI_RRESP = '0; M_AXI_RLAST = 1'b0; M_AXI_RDATA = '0;
    repeat (3) tick();

    // Reset values and constant AXI attributes
    chk("rst_accept", tlp_in_accept_data, 1'b0);
    chk("rst_src_rdy_n", tlp_out_src_rdy_n, 1'b1);
    chk("rst_req_to_send", tlp_out_req_to_send, 1'b0);
    chk("rst_awvalid", M_AXI_AWVALID, 1'b0);
    chk("rst_wvalid", M_AXI_WVALID, 1'b0);
    chk("rst_arvalid", M_AXI_ARVALID, 1'b0);
    chk("rst_bready", M_AXI_BREADY, 1'b0);
    chk("rst_rready", M_AXI_RREADY, 1'b0);
    chk("rst_cpl_fmt", tlp_out_fmt_type, 7'h00);
    chk("const_awsize", M_AXI_AWSIZE, 3'b010);
    chk("const_arburst", M_AXI_ARBURST, 2'b01);
    chk("const_awlen", M_AXI_AWLEN, 8'h00);
    sys_reset_n = 1'b1;
    tick();

    // MWr32 with immediate ready, then MWr64 with an unaligned address
    wr_txn(7'h40, 64'h1000, 32'hDEADBEEF, 4'hF, 32'h0000_1000, 0);
    wr_txn(7'h60, 64'h1_0000_3007, 32'hA5A5_0F0F, 4'h8, 32'h0000_3004, 0);

    // MRd32 with a straightforward completion
    rd_txn(64'h2004, 24'h010203, 4'hF, 12'd4, 2'b01, 32'h12345678, 32'h0000_2004, 7'h04, 0, 0);
    // First enabled byte at offset 2
    rd_txn(64'h0010, 24'hABCDEF, 4'hC, 12'd2, 2'b10, 32'hCAFE_F00D, 32'h0000_0010, 7'h12, 0, 0);

    // AW stalled while W completes at once
    wr_txn(7'h40, 64'h4000, 32'h0BAD_F00D, 4'h3, 32'h0000_4000, 5);

    // Grant delayed 3 cycles, destination not ready for 2 cycles
    rd_txn(64'h7F_0000_0068, 24'h112233, 4'h2, 12'd1, 2'b00, 32'h8765_4321, 32'h0000_0068, 7'h69, 3, 2);

    // Unsupported fmt and bad-length read are consumed without traffic
    aw0 = aw_cnt; ar0 = ar_cnt; c0 = cpl_cnt;
    M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_ARREADY = 1'b1;
    send_tlp(7'h44, 64'h5000, 10'd1, 24'h0, 32'h1, 4'hF, 12'd4, 2'd0);
    repeat (5) tick();
    send_tlp(7'h00, 64'h5000, 10'd2, 24'h0, 32'h0, 4'hF, 12'd8, 2'd0);
    repeat (5) tick();
    chk("drop_no_aw", 64'(aw_cnt), 64'(aw0));
    chk("drop_no_ar", 64'(ar_cnt), 64'(ar0));
    chk("drop_no_cpl", 64'(cpl_cnt), 64'(c0));
    chk("drop_no_rts", tlp_out_req_to_send, 1'b0);
    chk("drop_no_awvalid", M_AXI_AWVALID, 1'b0);
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
    wr_txn(7'h40, 64'h6000, 32'h1357_9BDF, 4'hF, 32'h0000_6000, 0);

    // Reset in the middle of a read aborts it
    ar0 = ar_cnt; c0 = cpl_cnt;
    send_tlp(7'h00, 64'h8000, 10'd1, 24'h0, 32'h0, 4'hF, 12'd4, 2'd0);
    tick();
    chk("abort_arvalid_before", M_AXI_ARVALID, 1'b1);
    sys_reset_n = 1'b0;
    #1;
    chk("abort_arvalid_async", M_AXI_ARVALID, 1'b0);
    tick();
    sys_reset_n = 1'b1;
    M_AXI_ARREADY = 1'b1; M_AXI_RVALID = 1'b1; tlp_out_grant = 1'b1; tlp_out_dst_rdy_n = 1'b0;
    repeat (5) tick();
    chk("abort_no_ar", 64'(ar_cnt), 64'(ar0));
    chk("abort_no_cpl", 64'(cpl_cnt), 64'(c0));
    chk("abort_no_rts", tlp_out_req_to_send, 1'b0);
    chk("abort_src_rdy_n", tlp_out_src_rdy_n, 1'b1);
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; tlp_out_grant = 1'b0; tlp_out_dst_rdy_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlp_axi_master_bridge.md
Name: tlp_axi_master_bridge

Overview:
- Bridges inbound PCIe memory-request TLPs (already parsed by the PCIe core's receive path) onto an AXI4 master port.
- Memory writes become single-beat AXI writes and are posted; no completion is returned.
- Memory reads become single-beat AXI reads; the read data is returned as a CplD TLP on the transmit path.
- Sits between the PCIe transaction layer and the AXI interconnect of the register/peripheral space.

Parameters:
- AXI_ID_W, 4, width of AWID/BID/ARID/RID.
- AXI_ADDR_W, 32, AXI address width; taken from tlp_in_address[AXI_ADDR_W-1:0].
- AXI_DATA_W, 32, fixed at one DW.

Ports:
- sys_clk  in  1  single clock for everything.
- sys_reset_n  in  1  asynchronous, active-low reset.
- tlp_in_valid in 1, tlp_in_accept_data out 1: inbound handshake.
- tlp_in_fmt_type in 7, tlp_in_address in 64, tlp_in_length_in_dw in 10, tlp_in_attr in 2: request header fields.
- tlp_in_transaction_id in 24, tlp_in_data in 32, tlp_in_byte_en in 4, tlp_in_byte_count in 12: ID {req_id,tag}, payload DW, first-DW byte enables, byte count.
- tlp_out_req_to_send out 1, tlp_out_grant in 1: transmit arbitration.
- tlp_out_src_rdy_n out 1, tlp_out_dst_rdy_n in 1: transmit data handshake, active-low.
- tlp_out_fmt_type out 7, tlp_out_length_in_dw out 10, tlp_out_data out 32, tlp_out_address out 64, tlp_out_ldwbe_fdwbe out 8: completion header and data.
- tlp_out_attr out 2, tlp_out_transaction_id out 24, tlp_out_byte_count out 12, tlp_out_lower_address out 7: completion fields.
- AW channel: M_AXI_AWREADY in 1; M_AXI_AWVALID out 1; M_AXI_AWID out AXI_ID_W; M_AXI_AWADDR out AXI_ADDR_W; M_AXI_AWLEN out 8; M_AXI_AWSIZE out 3; M_AXI_AWBURST out 2; M_AXI_AWPROT out 3.
- W/B channels: M_AXI_WREADY in 1; M_AXI_WVALID out 1; M_AXI_WDATA out 32; M_AXI_WSTRB out 4; M_AXI_WLAST out 1; M_AXI_BVALID in 1; M_AXI_BREADY out 1; M_AXI_BID in AXI_ID_W; M_AXI_BRESP in 2.
- AR/R channels: M_AXI_ARREADY in 1; M_AXI_ARVALID out 1; M_AXI_ARID out AXI_ID_W; M_AXI_ARADDR out AXI_ADDR_W; M_AXI_ARLEN out 8; M_AXI_ARSIZE out 3; M_AXI_ARBURST out 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1; M_AXI_RID in AXI_ID_W; M_AXI_RRESP in 2; M_AXI_RLAST in 1; M_AXI_RDATA in 32.

Behaviour:
- Reset: all outputs 0 except tlp_out_src_rdy_n=1; FSM goes to IDLE.
- Constant outputs: AxID=0, AxLEN=0, AxSIZE=3'b010, AxBURST=2'b01 (INCR), AWPROT=0, WLAST=1.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, CPL_REQ, CPL_DATA.
- IDLE, tlp_in_valid=1: pulse tlp_in_accept_data for 1 cycle and register all tlp_in_* fields. Decode fmt_type:
  - 0x40/0x60 (MWr32/64) -> WR_REQ.
  - 0x00/0x20 (MRd32/64) -> RD_REQ.
  - Anything else, or length_in_dw != 1 -> dropped, back to IDLE.
- WR_REQ:
  - AWVALID and WVALID rise together on the cycle after accept; AWADDR = {addr[AXI_ADDR_W-1:2],2'b00}; WDATA = data; WSTRB = byte_en.
  - Each VALID drops independently on its READY.
  - When both channels are done -> WR_RESP.
- WR_RESP: BREADY=1; on BVALID -> IDLE. BRESP is ignored.
- RD_REQ: ARVALID=1 until ARREADY -> RD_DATA.
- RD_DATA: RREADY=1; on RVALID latch RDATA -> CPL_REQ.
- CPL_REQ: tlp_out_req_to_send=1 until tlp_out_grant=1 -> CPL_DATA.
- CPL_DATA:
  - tlp_out_src_rdy_n=0 with stable fields: fmt_type=0x4A, length_in_dw=1, data=latched RDATA, attr/transaction_id echoed, byte_count=latched tlp_in_byte_count.
  - lower_address = {addr[6:2], offset of first set byte_en bit}; ldwbe_fdwbe = {4'h0, byte_en}; address = latched address.
  - Leaves on the cycle where tlp_out_dst_rdy_n=0: src_rdy_n returns to 1 and req_to_send to 0 -> IDLE.
- Only one outstanding request; tlp_in_accept_data=0 outside IDLE.
- Reset asserted mid-transaction aborts immediately; no AXI or TLP completion is generated afterwards.

Optional Feature:
- TLP2AXI_UR_CPL_EN defined:
  - Dropped reads (bad length or unknown read type) send a Cpl (fmt 0x0A, length 0) with status UR in transaction handling.
  - A read returning RRESP != OKAY produces a Cpl with status CA and no data.
- TLP2AXI_UR_CPL_EN undefined: such requests are silently dropped, and RRESP is ignored (data is returned as received).

Decomposition:
- Shared package tlp_axi_pkg: fmt_type constants (MRD32, MRD64, MWR32, MWR64, CPL, CPLD), AXI size/burst/resp constants, FSM state enum.
- One natural sub-module: tlp_cpl_builder (computes lower_address and formats the completion fields).

Test Plan:
- MWr32 addr 0x1000, data 0xDEADBEEF, be 0xF -> AWADDR 0x1000, WDATA 0xDEADBEEF, WSTRB 0xF; BREADY until BVALID; no TLP out.
- MRd32 addr 0x2004, tid 0x01_0203, be 0xF; slave returns 0x12345678 -> CplD fmt 0x4A, len 1, data 0x12345678, tid 0x010203, lower_address 0x04.
- MRd with be 0xC at addr 0x0010 -> lower_address 0x12.
- AWREADY delayed 5 cycles while WREADY is immediate -> WVALID drops after 1 cycle, AWVALID held 5 cycles, single write only.
- Grant delayed 3 cycles, dst_rdy_n high 2 cycles -> req_to_send held, data stable until dst_rdy_n=0.
- Unsupported fmt 0x44 -> accepted, no AXI activity, FSM returns to IDLE.
